// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared constants and types for the CNN frame feeder
package cnn_pkg;

  localparam int IMG_SIZE = 1024;
  localparam int PIX_W    = 8;

  typedef enum logic [1:0] {
    FS_IDLE     = 2'd0,
    FS_START    = 2'd1,
    FS_STREAM   = 2'd2,
    FS_WAIT_RES = 2'd3
  } feeder_state_e;

  typedef struct packed {
    logic             cls;
    logic [PIX_W-1:0] conf;
  } cnn_result_t;

  // Counter width able to hold max_val, never narrower than one bit
  function automatic int cnt_w(input int max_val);
    if (max_val < 1) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cnn_pace_ctr.sv
// rtl/cnn_pace_ctr.sv - GAP pacing counter and src_ready generation
module cnn_pace_ctr #(
  parameter int GAP = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic active_i,
  input  logic hs_i,
  output logic ready_o
);
  import cnn_pkg::*;

  localparam int GW = cnt_w(GAP);

  logic [GW-1:0] gap_q, gap_d;

  always_comb begin
    gap_d = gap_q;
    if (clear_i) begin
      gap_d = '0;
    end else if (hs_i) begin
      gap_d = GW'(GAP);
    end else if (gap_q != '0) begin
      gap_d = gap_q - GW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) gap_q <= '0;
    else     gap_q <= gap_d;
  end

  // Depends only on state and gap count, never on src_valid
  assign ready_o = active_i && (gap_q == '0);

endmodule

// File: rtl/cnn_frame_feeder.sv
// rtl/cnn_frame_feeder.sv - frames an upstream pixel stream for the CNN engine
module cnn_frame_feeder #(
  parameter int IMG_SIZE = cnn_pkg::IMG_SIZE,
  parameter int GAP      = 0,
  parameter int TIMEOUT  = 4095
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      src_valid,
  input  logic [cnn_pkg::PIX_W-1:0] src_data,
  output logic                      src_ready,
  output logic [cnn_pkg::PIX_W-1:0] pixel_out,
  output logic                      pixel_valid,
  output logic                      frame_start,
  input  logic                      cnn_busy,
  input  logic                      cnn_ready,
  input  logic                      cnn_class,
  input  logic [cnn_pkg::PIX_W-1:0] cnn_conf,
  output logic                      result_valid,
  output logic                      result_class,
  output logic [cnn_pkg::PIX_W-1:0] result_conf,
  output logic                      feeder_busy,
  output logic                      timeout_err,
  output logic [15:0]               frame_count
);
  import cnn_pkg::*;

  localparam int PW = cnt_w(IMG_SIZE);
  localparam int TW = cnt_w(TIMEOUT);

  localparam logic [1:0] IDLE     = FS_IDLE;
  localparam logic [1:0] START    = FS_START;
  localparam logic [1:0] STREAM   = FS_STREAM;
  localparam logic [1:0] WAIT_RES = FS_WAIT_RES;

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    pix_cnt_q, pix_cnt_d;
  logic [TW-1:0]    to_cnt_q, to_cnt_d;
  logic             pv_q, pv_d;
  logic [PIX_W-1:0] pix_out_q, pix_out_d;
  logic             rv_q, rv_d;
  cnn_result_t      res_q, res_d;
  logic             terr_q, terr_d;
  logic [15:0]      fc_q, fc_d;

  logic pace_ready;
  logic hs;
  logic last_beat;

  cnn_pace_ctr #(
    .GAP(GAP)
  ) u_pace (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (state_q == START),
    .active_i (state_q == STREAM),
    .hs_i     (hs),
    .ready_o  (pace_ready)
  );

  assign hs        = src_valid && pace_ready;
  assign last_beat = (pix_cnt_q == PW'(IMG_SIZE - 1));

  always_comb begin
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    to_cnt_d  = to_cnt_q;
    pv_d      = 1'b0;
    pix_out_d = pix_out_q;
    rv_d      = 1'b0;
    res_d     = res_q;
    terr_d    = terr_q;
    fc_d      = fc_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !cnn_busy) begin
            state_d = START;
            terr_d  = 1'b0;
          end
        end
        START: begin
          pix_cnt_d = '0;
          state_d   = STREAM;
        end
        STREAM: begin
          if (hs) begin
            pv_d      = 1'b1;
            pix_out_d = src_data;
            pix_cnt_d = pix_cnt_q + PW'(1);
            if (last_beat) begin
              state_d  = WAIT_RES;
              // to_cnt counts WAIT_RES cycles including the current one
              to_cnt_d = TW'(1);
            end
          end
        end
        WAIT_RES: begin
          to_cnt_d = to_cnt_q + TW'(1);
          if (cnn_ready) begin
            res_d.cls  = cnn_class;
            res_d.conf = cnn_conf;
            rv_d       = 1'b1;
            fc_d       = fc_q + 16'd1;
            state_d    = IDLE;
          end else if (to_cnt_q == TW'(TIMEOUT)) begin
            terr_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pix_cnt_q <= '0;
      to_cnt_q  <= '0;
      pv_q      <= 1'b0;
      pix_out_q <= '0;
      rv_q      <= 1'b0;
      res_q     <= '0;
      terr_q    <= 1'b0;
      fc_q      <= '0;
    end else begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
      to_cnt_q  <= to_cnt_d;
      pv_q      <= pv_d;
      pix_out_q <= pix_out_d;
      rv_q      <= rv_d;
      res_q     <= res_d;
      terr_q    <= terr_d;
      fc_q      <= fc_d;
    end
  end

  assign src_ready    = pace_ready;
  assign pixel_out    = pix_out_q;
  assign pixel_valid  = pv_q && !abort;
  assign frame_start  = (state_q == START) && !abort;
  assign result_valid = rv_q;
  assign result_class = res_q.cls;
  assign result_conf  = res_q.conf;
  assign feeder_busy  = (state_q != IDLE);
  assign timeout_err  = terr_q;
  assign frame_count  = fc_q;

endmodule
